// File: rtl/tx_ordered_set_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package : tx_ordered_set_gen_pkg
// Symbol codes, ordered-set type codes and sequencer states for the Tx path.
// Rev     : 1.0
// ============================================================================
package tx_ordered_set_gen_pkg;

    localparam logic [7:0] SYM_COM = 8'hBC;   // K28.5
    localparam logic [7:0] SYM_SKP = 8'h1C;   // K28.0
    localparam logic [7:0] SYM_IDL = 8'h7C;   // K28.3
    localparam logic [7:0] SYM_FTS = 8'h3C;   // K28.1
    localparam logic [7:0] SYM_PAD = 8'hF7;   // K23.7
    localparam logic [7:0] TS1_ID  = 8'h4A;   // D10.2
    localparam logic [7:0] TS2_ID  = 8'h45;   // D5.2
    localparam logic [7:0] RATE_ID = 8'h02;

    localparam logic [2:0] OS_TS1  = 3'd1;
    localparam logic [2:0] OS_TS2  = 3'd2;
    localparam logic [2:0] OS_EIOS = 3'd3;
    localparam logic [2:0] OS_FTS  = 3'd4;
    localparam logic [2:0] OS_SKP  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_OS    = 2'd2,
        ST_EIDLE = 2'd3
    } tx_state_t;

    function automatic logic os_type_legal(input logic [2:0] os_type);
        return (os_type >= OS_TS1) && (os_type <= OS_SKP);
    endfunction

    function automatic logic os_is_ts(input logic [2:0] os_type);
        return (os_type == OS_TS1) || (os_type == OS_TS2);
    endfunction

    function automatic logic os_exits_eidle(input logic [2:0] os_type);
        return os_is_ts(os_type) || (os_type == OS_FTS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_skp_timer.sv
`default_nettype none
// ============================================================================
// Module : tx_skp_timer
// Free-running SKP interval counter; raises pending at the end of the period.
// Rev    : 1.0
// ============================================================================
module tx_skp_timer #(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic pending
);

    localparam int CW = (SKP_INTERVAL > 2) ? $clog2(SKP_INTERVAL) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(SKP_INTERVAL - 1);

    logic [CW-1:0] r_count;

    // Saturates at the last count so pending stays up until a SKP goes out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            pending <= 1'b0;
        end else if (clear || !enable) begin
            r_count <= '0;
            pending <= 1'b0;
        end else if (r_count == C_LAST) begin
            pending <= 1'b1;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_ordered_set_gen.sv
`default_nettype none
// ============================================================================
// Module : tx_ordered_set_gen
// PCIe Tx sequencer: data pass-through, logical idle, ordered sets, SKP insertion.
// Rev    : 1.0
// ============================================================================
module tx_ordered_set_gen #(
    parameter int         SKP_INTERVAL = 1180,
    parameter int         SKP_COUNT    = 3,
    parameter logic [7:0] IDLE_BYTE    = 8'h00
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       OsReq,
    input  logic [2:0] OsType,
    output logic       OsAck,
    input  logic       TxDataValid,
    input  logic [7:0] TxData,
    input  logic       TxDataCtrl,
    input  logic       TxDataEnd,
    output logic       TxDataReady,
    input  logic [7:0] LinkNum,
    input  logic       LinkPad,
    input  logic [4:0] LaneNum,
    input  logic       LanePad,
    input  logic [7:0] NFts,
    input  logic [3:0] TrainCtrl,
    input  logic       SkpEnable,
    input  logic       DisableScramble,
    output logic [7:0] TxByte,
    output logic       TxCtrl,
    output logic       TxElecIdle,
    output logic       notResetScrambler,
    output logic       MoveScrambler,
    output logic       Scramble
);
    import tx_ordered_set_gen_pkg::*;

    tx_state_t  r_state, w_state;
    logic [3:0] r_idx, w_idx;
    logic [2:0] r_kind, w_kind;
    logic [3:0] w_last_idx;
    logic [7:0] w_byte;
    logic       w_ctrl, w_eidle, w_ack, w_in_ts, w_ready;
    logic       w_start;
    logic [2:0] w_start_kind;
    logic       w_req, w_skp_pending, w_skp_clear;

    // The requester drops OsReq after seeing OsAck; masking avoids a second serve that cycle.
    assign w_req       = OsReq & ~OsAck;
    assign w_skp_clear = w_start && (w_start_kind == OS_SKP);
    assign TxDataReady = w_ready & ~Reset;

    tx_skp_timer #(
        .SKP_INTERVAL(SKP_INTERVAL)
    ) u_skp_timer (
        .clk    (Clk),
        .rst    (Reset),
        .enable (SkpEnable),
        .clear  (w_skp_clear),
        .pending(w_skp_pending)
    );

    always_comb begin
        case (r_kind)
            OS_TS1, OS_TS2: w_last_idx = 4'd15;
            OS_SKP:         w_last_idx = 4'(SKP_COUNT);
            default:        w_last_idx = 4'd3;
        endcase
    end

    always_comb begin
        w_state      = r_state;
        w_idx        = r_idx;
        w_kind       = r_kind;
        w_byte       = IDLE_BYTE;
        w_ctrl       = 1'b0;
        w_eidle      = 1'b0;
        w_ack        = 1'b0;
        w_in_ts      = 1'b0;
        w_ready      = 1'b0;
        w_start      = 1'b0;
        w_start_kind = OS_SKP;

        case (r_state)
            ST_IDLE: begin
                if (w_skp_pending) begin
                    w_start = 1'b1;
                    w_ack   = w_req && (OsType == OS_SKP);
                end else if (w_req) begin
                    w_ack        = 1'b1;
                    w_start      = os_type_legal(OsType);
                    w_start_kind = OsType;
                end else begin
                    w_ready = 1'b1;
                    if (TxDataValid) begin
                        w_byte = TxData;
                        w_ctrl = TxDataCtrl;
                        if (!TxDataEnd) w_state = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                w_ready = 1'b1;
                if (TxDataValid) begin
                    w_byte = TxData;
                    w_ctrl = TxDataCtrl;
                    if (TxDataEnd) w_state = ST_IDLE;
                end
            end
            ST_OS: begin
                w_ctrl = 1'b1;
                case (r_kind)
                    OS_TS1, OS_TS2: begin
                        w_in_ts = 1'b1;
                        w_ctrl  = 1'b0;
                        case (r_idx)
                            4'd1: begin
                                w_byte = LinkPad ? SYM_PAD : LinkNum;
                                w_ctrl = LinkPad;
                            end
                            4'd2: begin
                                w_byte = LanePad ? SYM_PAD : {3'b000, LaneNum};
                                w_ctrl = LanePad;
                            end
                            4'd3:    w_byte = NFts;
                            4'd4:    w_byte = RATE_ID;
                            4'd5:    w_byte = {4'h0, TrainCtrl};
                            default: w_byte = (r_kind == OS_TS2) ? TS2_ID : TS1_ID;
                        endcase
                    end
                    OS_EIOS: w_byte = SYM_IDL;
                    OS_FTS:  w_byte = SYM_FTS;
                    default: w_byte = SYM_SKP;
                endcase
                if (r_idx == w_last_idx) begin
                    w_idx   = 4'd0;
                    w_state = (r_kind == OS_EIOS) ? ST_EIDLE : ST_IDLE;
                end else begin
                    w_idx = r_idx + 4'd1;
                end
            end
            ST_EIDLE: begin
                w_eidle = 1'b1;
                w_byte  = 8'h00;
                if (w_req) begin
                    if (os_exits_eidle(OsType)) begin
                        w_start      = 1'b1;
                        w_start_kind = OsType;
                        w_ack        = 1'b1;
                    end else if (!os_type_legal(OsType)) begin
                        w_ack = 1'b1;
                    end
                end
            end
            default: w_state = ST_IDLE;
        endcase

        // COM of a new set overrides whatever the state chose for this symbol.
        if (w_start) begin
            w_state = ST_OS;
            w_idx   = 4'd1;
            w_kind  = w_start_kind;
            w_byte  = SYM_COM;
            w_ctrl  = 1'b1;
            w_eidle = 1'b0;
            w_in_ts = os_is_ts(w_start_kind);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state           <= ST_IDLE;
            r_idx             <= 4'd0;
            r_kind            <= 3'd0;
            OsAck             <= 1'b0;
            TxByte            <= 8'h00;
            TxCtrl            <= 1'b0;
            TxElecIdle        <= 1'b0;
            notResetScrambler <= 1'b0;
            MoveScrambler     <= 1'b0;
            Scramble          <= 1'b0;
        end else begin
            r_state           <= w_state;
            r_idx             <= w_idx;
            r_kind            <= w_kind;
            OsAck             <= w_ack;
            TxByte            <= w_byte;
            TxCtrl            <= w_ctrl;
            TxElecIdle        <= w_eidle;
            notResetScrambler <= ~(w_ctrl && (w_byte == SYM_COM));
            MoveScrambler     <= ~(w_ctrl && (w_byte == SYM_SKP));
            Scramble          <= ~(w_ctrl | w_in_ts | DisableScramble | w_eidle);
        end
    end

endmodule
`default_nettype wire
